// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter and cycle generator for the RTC multiplexed address/data bus.
// Optional burst mode under macro RTC_BURST_EN: an owner with req still high keeps the bus.
module rtc_bus_arbiter #(
  parameter int N_CH      = 4,
  parameter int T_PULSE   = 4,
  parameter int T_HOLD    = 2,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   req_wr,
  input  logic [8*N_CH-1:0] req_addr,
  input  logic [8*N_CH-1:0] req_wdata,
  output logic [N_CH-1:0]   gnt,
  output logic [N_CH-1:0]   done,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic              a_d,
  output logic              cs,
  output logic              rd,
  output logic              wr,
  output logic [7:0]        ad_out,
  output logic              ad_oe,
  input  logic [7:0]        ad_in
);

  localparam int         PW         = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [3:0] PULSE_LAST = 4'(T_PULSE - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(T_HOLD - 1);

  if (N_CH < 2 || N_CH > 8 || T_PULSE < 1 || T_PULSE > 15 ||
      T_HOLD < 1 || T_HOLD > 15 || BURST_MAX < 1) begin : g_param_err
    $error("rtc_bus_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_H, S_DATA, S_DATA_H, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N_CH-1:0] gnt_q, gnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            wr_q, wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
`ifdef RTC_BURST_EN
  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  logic [7:0]      burst_q, burst_d;
`endif

  logic            win_found;
  logic [PW-1:0]   win_idx;
  int              cand;

  // Search starts one past the last owner, so the last owner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = 0;
    for (int i = 1; i <= N_CH; i++) begin
      cand = (int'(ptr_q) + i) % N_CH;
      if (!win_found && req[PW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(N_CH - 1);
      gnt_q   <= '0;
      rdata_q <= '0;
`ifdef RTC_BURST_EN
      burst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
`ifdef RTC_BURST_EN
      burst_q <= burst_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef RTC_BURST_EN
    burst_d = burst_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_ADDR;
          cnt_d   = PULSE_LAST;
          ptr_d   = win_idx;
          gnt_d   = N_CH'(1) << win_idx;
          wr_d    = req_wr[win_idx];
          addr_d  = req_addr[8*win_idx +: 8];
          wdata_d = req_wdata[8*win_idx +: 8];
`ifdef RTC_BURST_EN
          burst_d = 8'd1;
`endif
        end
      end
      S_ADDR: begin
        if (cnt_q == 4'd0) begin
          state_d = S_ADDR_H;
          cnt_d   = HOLD_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ADDR_H: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
          cnt_d   = PULSE_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 4'd0) begin
          if (!wr_q) rdata_d = ad_in;
          state_d = S_DATA_H;
          cnt_d   = HOLD_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DATA_H: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
`ifdef RTC_BURST_EN
        // Owner keeps the bus without a turnaround cycle; pointer stays put.
        if (req[ptr_q] && burst_q < BURST_LIM) begin
          state_d = S_ADDR;
          gnt_d   = gnt_q;
          cnt_d   = PULSE_LAST;
          wr_d    = req_wr[ptr_q];
          addr_d  = req_addr[8*ptr_q +: 8];
          wdata_d = req_wdata[8*ptr_q +: 8];
          burst_d = burst_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins decode straight from state so reset idles them without a clock.
  always_comb begin
    a_d    = 1'b1;
    cs     = 1'b1;
    rd     = 1'b1;
    wr     = 1'b1;
    ad_oe  = 1'b0;
    ad_out = 8'h00;
    case (state_q)
      S_ADDR: begin
        a_d    = 1'b0;
        cs     = 1'b0;
        wr     = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_ADDR_H: begin
        a_d    = 1'b0;
        ad_oe  = 1'b1;
        ad_out = addr_q;
      end
      S_DATA: begin
        cs = 1'b0;
        if (wr_q) begin
          wr     = 1'b0;
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end else begin
          rd = 1'b0;
        end
      end
      S_DATA_H: begin
        if (wr_q) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
      end
      default: ;
    endcase
  end

  assign gnt   = gnt_q;
  assign done  = (state_q == S_DONE) ? gnt_q : '0;
  assign rdata = rdata_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter with default timing (T_PULSE=4, T_HOLD=2, N_CH=4).
// Build with +define+RTC_BURST_EN to exercise the burst path.
module tb_rtc_bus_arbiter;

  localparam int N_CH = 4;
`ifdef RTC_BURST_EN
  localparam int NB = 4;
`else
  localparam int NB = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH-1:0]   req, req_wr;
  logic [8*N_CH-1:0] req_addr, req_wdata;
  logic [N_CH-1:0]   gnt, done;
  logic [7:0]        rdata, ad_out, ad_in;
  logic              busy, a_d, cs, rd, wr, ad_oe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rtc_bus_arbiter #(.N_CH(N_CH), .T_PULSE(4), .T_HOLD(2), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .a_d(a_d), .cs(cs), .rd(rd), .wr(wr), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {a_d,cs,rd,wr,ad_oe,ad_out} on cycle c of a transaction (ADDR starts at c=1).
  function automatic logic [12:0] exp_bus(int c, logic is_wr, logic [7:0] a, logic [7:0] d);
    if (c >= 1 && c <= 4)   return {5'b00101, a};
    if (c >= 5 && c <= 6)   return {5'b01111, a};
    if (c >= 7 && c <= 10)  return is_wr ? {5'b10101, d} : {5'b10010, 8'h00};
    if (c >= 11 && c <= 12) return is_wr ? {5'b11111, d} : {5'b11110, 8'h00};
    return {5'b11110, 8'h00};
  endfunction

  function automatic logic [12:0] obs_bus();
    return {a_d, cs, rd, wr, ad_oe, (ad_oe ? ad_out : 8'h00)};
  endfunction

  task automatic set_ch(int ch, logic w, logic [7:0] a, logic [7:0] d);
    req_wr[ch]        = w;
    req_addr[8*ch+:8] = a;
    req_wdata[8*ch+:8] = d;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; ad_in = 8'h00;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && busy; n++) tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; ad_in = 8'h00;
    #3;
    checks++;
    if ({gnt, done, rdata, busy, a_d, cs, rd, wr, ad_out, ad_oe} !==
        {4'h0, 4'h0, 8'h00, 1'b0, 4'b1111, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_async gnt=%b done=%b rdata=%h busy=%b a_d/cs/rd/wr=%b%b%b%b ad_out=%h oe=%b, want all idle",
               gnt, done, rdata, busy, a_d, cs, rd, wr, ad_out, ad_oe);
    end
    tick(); tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({gnt, done, busy, cs, ad_oe} !== {4'h0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle gnt=%b done=%b busy=%b cs=%b oe=%b, want 0 0 0 1 0",
               gnt, done, busy, cs, ad_oe);
    end
  endtask

  task automatic test_single_write();
    logic [3:0] eg, ed;
    apply_reset();
    set_ch(1, 1'b1, 8'h21, 8'h59);
    req = 4'b0010;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      eg = (c <= 13) ? 4'b0010 : 4'b0000;
      ed = (c == 13) ? 4'b0010 : 4'b0000;
      checks++;
      if ({obs_bus(), gnt, done} !== {exp_bus(c, 1'b1, 8'h21, 8'h59), eg, ed}) begin
        errors++;
        $display("FAIL write_cycle%0d bus=%h gnt=%b done=%b, want bus=%h gnt=%b done=%b",
                 c, obs_bus(), gnt, done, exp_bus(c, 1'b1, 8'h21, 8'h59), eg, ed);
      end
    end
  endtask

  task automatic test_single_read();
    logic [3:0] eg, ed;
    apply_reset();
    set_ch(2, 1'b0, 8'h23, 8'h00);
    req = 4'b0100;
    ad_in = 8'hAA;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
      ad_in = (c >= 7 && c <= 10) ? 8'h17 : 8'hAA;
      eg = (c <= 13) ? 4'b0100 : 4'b0000;
      ed = (c == 13) ? 4'b0100 : 4'b0000;
      checks++;
      if ({obs_bus(), gnt, done} !== {exp_bus(c, 1'b0, 8'h23, 8'h00), eg, ed}) begin
        errors++;
        $display("FAIL read_cycle%0d bus=%h gnt=%b done=%b, want bus=%h gnt=%b done=%b",
                 c, obs_bus(), gnt, done, exp_bus(c, 1'b0, 8'h23, 8'h00), eg, ed);
      end
      if (c >= 13) begin
        checks++;
        if (rdata !== 8'h17) begin
          errors++;
          $display("FAIL read_rdata_cycle%0d rdata=%h, want 17", c, rdata);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] eg;
    reset = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) set_ch(ch, 1'b1, 8'(8'h40 + ch), 8'(8'h80 + ch));
    req = 4'b1111;
    tick(); tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      eg = 4'(1 << order[k]);
      for (int n = 0; n < 20 && gnt == 4'b0000; n++) tick();
      checks++;
      if (gnt !== eg) begin
        errors++;
        $display("FAIL rr_grant%0d gnt=%b, want %b", k, gnt, eg);
      end
      for (int n = 0; n < 20 && done == 4'b0000; n++) tick();
      checks++;
      if (done !== eg) begin
        errors++;
        $display("FAIL rr_done%0d done=%b, want %b", k, done, eg);
      end
      if (k == 4) req = 4'b0000;
      tick();
      checks++;
      if ({busy, gnt} !== 5'b0_0000) begin
        errors++;
        $display("FAIL rr_gap%0d busy=%b gnt=%b, want 0 0000", k, busy, gnt);
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    int dn;
    apply_reset();
    set_ch(1, 1'b1, 8'h44, 8'h99);
    set_ch(3, 1'b1, 8'h33, 8'h66);
    req = 4'b0010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) req = 4'b0000;
    end
    checks++;
    if ({a_d, wr, ad_out} !== {1'b1, 1'b0, 8'h99}) begin
      errors++;
      $display("FAIL areset_pre a_d=%b wr=%b ad_out=%h, want 1 0 99", a_d, wr, ad_out);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({a_d, cs, rd, wr, ad_oe, done, gnt, busy} !== {5'b11110, 4'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL areset_idle a_d/cs/rd/wr/oe=%b%b%b%b%b done=%b gnt=%b busy=%b, want 11110 0000 0000 0",
               a_d, cs, rd, wr, ad_oe, done, gnt, busy);
    end
    dn = 0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (done != 4'b0000) dn++;
    end
    checks++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL areset_nodone done_cycles=%0d, want 0", dn);
    end
    reset = 1'b1;
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL areset_rr gnt=%b, want 0010", gnt);
    end
    req = 4'b0000;
    drain();
  endtask

  task automatic test_drop_req();
    int bc;
    apply_reset();
    set_ch(3, 1'b1, 8'h30, 8'hA5);
    req = 4'b1000;
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 5) req = 4'b0000;
    end
    checks++;
    if (done !== 4'b1000) begin
      errors++;
      $display("FAIL drop_done done=%b, want 1000", done);
    end
    bc = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (busy) bc++;
    end
    checks++;
    if (bc !== 0) begin
      errors++;
      $display("FAIL drop_no_retx busy_cycles=%0d, want 0", bc);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    set_ch(0, 1'b1, 8'h10, 8'h01);
    set_ch(1, 1'b1, 8'h11, 8'h02);
    req = 4'b0011;
    for (int t = 0; t < NB; t++) begin
      for (int c = 1; c <= 13; c++) begin
        tick();
        if (c == 1) begin
          checks++;
          if ({busy, a_d, gnt} !== {2'b10, 4'b0001}) begin
            errors++;
            $display("FAIL b2b_start%0d busy=%b a_d=%b gnt=%b, want 1 0 0001", t, busy, a_d, gnt);
          end
        end
        if (c == 13) begin
          checks++;
          if (done !== 4'b0001) begin
            errors++;
            $display("FAIL b2b_done%0d done=%b, want 0001", t, done);
          end
        end
      end
    end
    tick();
    checks++;
    if ({busy, gnt} !== 5'b0_0000) begin
      errors++;
      $display("FAIL b2b_gap busy=%b gnt=%b, want 0 0000", busy, gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_next gnt=%b, want 0010", gnt);
    end
    req = 4'b0000;
    drain();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_round_robin();
    test_async_reset();
    test_drop_req();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_bus_arbiter.md
Name: rtc_bus_arbiter

Overview:
- Parametrised successor to the fixed two-controller write/read mux on the RTC multiplexed address/data bus.
- N independent requesters (write FSM, read FSM, timer, init, …) issue single-register transactions.
- Round-robin arbitration; the block itself generates the a_d/cs/rd/wr cycle timing with programmable phase lengths, drives/samples the 8-bit AD bus, and returns per-channel completion.
- Sits between the controller FSMs and the top-level RTC pins.

Parameters:
- N_CH, 4, number of requesting channels (2..8)
- T_PULSE, 4, cycles cs and rd/wr held low in each phase (1..15)
- T_HOLD, 2, cycles after strobe release with AD/a_d held stable (1..15)
- BURST_MAX, 4, max back-to-back transactions per grant (burst feature only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req  in  N_CH  per-channel transaction request (level)
- req_wr  in  N_CH  1 = write, 0 = read, per channel
- req_addr  in  8*N_CH  register address; channel i at [8i+7:8i]
- req_wdata  in  8*N_CH  write data; channel i at [8i+7:8i]
- gnt  out  N_CH  one-hot owner of the current transaction
- done  out  N_CH  one-cycle completion pulse to the owner
- rdata  out  8  read data, valid while done pulses and held until the next read
- busy  out  1  high whenever state ≠ IDLE
- a_d  out  1  0 = address phase, 1 = data phase
- cs  out  1  chip select, active low
- rd  out  1  read strobe, active low
- wr  out  1  write strobe, active low
- ad_out  out  8  value driven on AD bus
- ad_oe  out  1  AD tristate enable (1 = drive)
- ad_in  in  8  AD bus sampled value

Behaviour:
- Reset (async, reset=0): state IDLE; gnt=0; done=0; rdata=0; busy=0; a_d=1; cs=1; rd=1; wr=1; ad_out=0; ad_oe=0; RR pointer = N_CH-1, so channel 0 wins first.
- States: IDLE, ADDR, ADDR_H, DATA, DATA_H, DONE.
- IDLE:
  - If any req bit is set, grant the first requester at or after pointer+1 (modulo N_CH).
  - Register gnt, latch req_wr/addr/wdata of the winner, load counter, go to ADDR.
  - Pointer updates to the winner.
- ADDR (T_PULSE cycles): a_d=0, cs=0, wr=0, rd=1, ad_oe=1, ad_out=addr.
- ADDR_H (T_HOLD cycles): cs=1, wr=1; a_d=0, ad_oe=1, addr held.
- DATA (T_PULSE cycles): a_d=1, cs=0.
  - Write: wr=0, ad_oe=1, ad_out=wdata.
  - Read: rd=0, ad_oe=0; ad_in captured into rdata on the last DATA cycle.
- DATA_H (T_HOLD cycles): cs=1, rd=1, wr=1; a_d=1; write keeps ad_oe=1 with wdata, read keeps ad_oe=0.
- DONE (1 cycle): done[owner]=1, all strobes idle, ad_oe=0; next cycle IDLE with gnt=0.
- Latency: done pulses 2*T_PULSE+2*T_HOLD+1 cycles after the first ADDR cycle (13 with defaults).
- Back-to-back: at least one IDLE cycle between transactions (bus turnaround).
- Request inputs are sampled only in IDLE. Deasserting req mid-transaction does not abort it; the transaction completes and done still pulses.
- Simultaneous requests: strict round-robin; no channel waits more than N_CH-1 transactions.
- rd and wr never low in the same cycle. ad_oe=0 whenever rd=0.
- Async reset mid-transaction: all strobes go idle immediately, no done pulse.

Optional Feature:
- Macro: RTC_BURST_EN.
- Defined:
  - After DONE, if the owner's req is still high and fewer than BURST_MAX transactions have run under this grant, go directly to ADDR with fresh latched inputs. gnt stays set and the pointer does not advance.
  - Burst counter resets on grant change.
  - Turnaround IDLE cycle is skipped inside a burst.
- Undefined: every transaction re-arbitrates through IDLE; BURST_MAX is ignored.

Test Plan:
- Single write, ch1, addr=0x21, data=0x59, defaults:
  - ADDR: a_d=0, cs=0, wr=0, ad_out=0x21 for 4 cycles.
  - DATA: a_d=1, wr=0, ad_out=0x59 for 4 cycles.
  - done[1] 13 cycles after ADDR start; rd never low.
- Single read, ch2, addr=0x23, ad_in=0x17 during DATA:
  - ad_oe=0 while rd=0.
  - rdata=0x17 with done[2]=1.
- req=4'b1111 held continuously from reset: grant order 0,1,2,3,0; each done before the next gnt.
- Async reset during DATA of a write: cs, wr, rd, a_d=1 and ad_oe=0 the same cycle; no done; next req is served from channel 0 priority.
- ch3 drops req during ADDR_H: transaction completes, done[3] pulses, no second transaction.
- RTC_BURST_EN defined, BURST_MAX=4, ch0 req held:
  - Four contiguous transactions with no IDLE gap.
  - Then re-arbitration grants pending ch1.
